// File: rtl/transport_tx_arbiter.sv
// Shares the transport transmit port among session control, live audio and
// voicemail requesters, buffering their pulses and sequencing transport_busy.
module transport_tx_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 4,
  parameter int unsigned DROP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl_valid,
  input  logic [15:0]       ctl_data,
  input  logic              aud_valid,
  input  logic [15:0]       aud_data,
  input  logic              vm_valid,
  input  logic [15:0]       vm_data,
  output logic              vm_ready,
  input  logic              flush,
  input  logic              transport_busy,
  output logic              tx_start,
  output logic [1:0]        tx_cmd,
  output logic [15:0]       tx_data,
  output logic              aud_busy,
  output logic [DROP_W-1:0] aud_drop_count,
  output logic              ctl_overflow,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_CTL  = 2'b01;
  localparam logic [1:0] CMD_AUD  = 2'b10;
  localparam logic [1:0] CMD_VM   = 2'b11;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        tx_start_q, tx_start_d;
  logic [1:0]  tx_cmd_q, tx_cmd_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic        rr_vm_q, rr_vm_d;   // 1: last audio-class grant went to voicemail

  logic [15:0] ctl_mem_q [2];
  logic        ctl_wr_q, ctl_rd_q;
  logic [1:0]  ctl_cnt_q, ctl_cnt_d;
  logic        ctl_ovf_q;
  logic        aud_full_q;
  logic [15:0] aud_data_q;
  logic [DROP_W-1:0] drop_q;
  logic        vm_full_q;
  logic [15:0] vm_data_q;

  logic pop_ctl, pop_aud, pop_vm;
  logic ctl_accept, aud_push, aud_drop, vm_accept;

  // Arbitration and transport handshake
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_cmd_d   = tx_cmd_q;
    tx_data_d  = tx_data_q;
    rr_vm_d    = rr_vm_q;
    pop_ctl    = 1'b0;
    pop_aud    = 1'b0;
    pop_vm     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!transport_busy && ctl_cnt_q != 2'd0) begin
          pop_ctl   = 1'b1;
          tx_cmd_d  = CMD_CTL;
          tx_data_d = ctl_mem_q[ctl_rd_q];
        end else if (!transport_busy && aud_full_q && (!vm_full_q || rr_vm_q)) begin
          pop_aud   = 1'b1;
          tx_cmd_d  = CMD_AUD;
          tx_data_d = aud_data_q;
          rr_vm_d   = 1'b0;
        end else if (!transport_busy && vm_full_q) begin
          pop_vm    = 1'b1;
          tx_cmd_d  = CMD_VM;
          tx_data_d = vm_data_q;
          rr_vm_d   = 1'b1;
        end else begin
          tx_cmd_d  = CMD_NONE;
        end
        if (pop_ctl || pop_aud || pop_vm) begin
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (transport_busy) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TW'(BUSY_TIMEOUT)) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!transport_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Source acceptance; a full control FIFO still accepts when it pops this cycle
  always_comb begin
    ctl_accept = ctl_valid && (ctl_cnt_q != 2'd2 || pop_ctl);
    aud_push   = aud_valid && !flush;
    aud_drop   = aud_push && aud_full_q && !pop_aud;
    vm_accept  = vm_valid && !vm_full_q && !flush;
    ctl_cnt_d  = ctl_cnt_q;
    case ({ctl_accept, pop_ctl})
      2'b10:   ctl_cnt_d = ctl_cnt_q + 2'd1;
      2'b01:   ctl_cnt_d = ctl_cnt_q - 2'd1;
      default: ctl_cnt_d = ctl_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      tx_cmd_q   <= CMD_NONE;
      tx_data_q  <= '0;
      rr_vm_q    <= 1'b0;
      ctl_wr_q   <= 1'b0;
      ctl_rd_q   <= 1'b0;
      ctl_cnt_q  <= '0;
      ctl_ovf_q  <= 1'b0;
      aud_full_q <= 1'b0;
      aud_data_q <= '0;
      drop_q     <= '0;
      vm_full_q  <= 1'b0;
      vm_data_q  <= '0;
      ctl_mem_q[0] <= '0;
      ctl_mem_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_start_q <= tx_start_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_data_q  <= tx_data_d;
      rr_vm_q    <= rr_vm_d;
      ctl_cnt_q  <= ctl_cnt_d;

      if (ctl_accept) begin
        ctl_mem_q[ctl_wr_q] <= ctl_data;
        ctl_wr_q            <= ~ctl_wr_q;
      end
      if (pop_ctl) ctl_rd_q <= ~ctl_rd_q;
      if (ctl_valid && !ctl_accept) ctl_ovf_q <= 1'b1;

      if (flush) begin
        aud_full_q <= 1'b0;
      end else if (aud_push) begin
        aud_full_q <= 1'b1;
        aud_data_q <= aud_data;
      end else if (pop_aud) begin
        aud_full_q <= 1'b0;
      end
      if (aud_drop && drop_q != '1) drop_q <= drop_q + 1'b1;

      if (flush) begin
        vm_full_q <= 1'b0;
      end else if (vm_accept) begin
        vm_full_q <= 1'b1;
        vm_data_q <= vm_data;
      end else if (pop_vm) begin
        vm_full_q <= 1'b0;
      end
    end
  end

  assign vm_ready       = !vm_full_q;
  assign tx_start       = tx_start_q;
  assign tx_cmd         = tx_cmd_q;
  assign tx_data        = tx_data_q;
  assign aud_busy       = aud_full_q;
  assign aud_drop_count = drop_q;
  assign ctl_overflow   = ctl_ovf_q;
  assign arb_state      = state_q;

endmodule

// File: tb/tb_transport_tx_arbiter.sv
// Scoreboard bench for transport_tx_arbiter: directed stimulus queues expected
// packets, a monitor checks each tx_start against the queue head.
module tb_transport_tx_arbiter;

  localparam int unsigned TO = 4;
  localparam logic [1:0] C_CTL = 2'b01, C_AUD = 2'b10, C_VM = 2'b11;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ctl_valid = 1'b0, aud_valid = 1'b0, vm_valid = 1'b0, flush = 1'b0;
  logic [15:0] ctl_data = '0, aud_data = '0, vm_data = '0;
  logic        force_busy = 1'b0, resp_busy = 1'b0;
  logic        transport_busy;
  logic        vm_ready, tx_start, aud_busy, ctl_overflow;
  logic [1:0]  tx_cmd, arb_state;
  logic [15:0] tx_data;
  logic [7:0]  aud_drop_count;

  assign transport_busy = force_busy | resp_busy;

  transport_tx_arbiter #(.BUSY_TIMEOUT(TO), .DROP_W(8)) dut (
    .clk(clk), .reset(reset),
    .ctl_valid(ctl_valid), .ctl_data(ctl_data),
    .aud_valid(aud_valid), .aud_data(aud_data),
    .vm_valid(vm_valid), .vm_data(vm_data), .vm_ready(vm_ready),
    .flush(flush), .transport_busy(transport_busy),
    .tx_start(tx_start), .tx_cmd(tx_cmd), .tx_data(tx_data),
    .aud_busy(aud_busy), .aud_drop_count(aud_drop_count),
    .ctl_overflow(ctl_overflow), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0;
  int busy_len = 3;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] data;
    int          lo;
    int          hi;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_tx(input logic [1:0] c, input logic [15:0] d, input int lo, input int hi);
    exp_t e;
    e.cmd = c; e.data = d; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  // Monitor: every tx_start must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && tx_start) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_tx: got cmd %0d data %h at cycle %0d, required no packet",
                   tx_cmd, tx_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("tx_cmd", {30'd0, tx_cmd}, {30'd0, e.cmd});
          chk("tx_data", {16'd0, tx_data}, {16'd0, e.data});
          total++;
          if (cyc >= e.lo && cyc <= e.hi) passed++;
          else $display("FAIL tx_cycle: got %0d, required %0d..%0d", cyc, e.lo, e.hi);
        end
      end
    end
  end

  // Transport model: raises busy the cycle after tx_start for busy_len cycles
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_start && busy_len > 0) begin
        @(negedge clk);
        resp_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_ctl(input logic [15:0] d);
    ctl_valid = 1'b1; ctl_data = d; tick(); ctl_valid = 1'b0;
  endtask

  task automatic send_aud(input logic [15:0] d);
    aud_valid = 1'b1; aud_data = d; tick(); aud_valid = 1'b0;
  endtask

  task automatic send_vm(input logic [15:0] d);
    vm_valid = 1'b1; vm_data = d; tick(); vm_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(sb.size() == 0 && arb_state == 2'd0 && !transport_busy) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) begin
      total++;
      $display("FAIL %s_drain: got %0d packets outstanding after %0d cycles, required 0",
               name, sb.size(), budget);
    end
    repeat (6) tick();
  endtask

  initial begin
    int c;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_cmd", {30'd0, tx_cmd}, 32'd0);
    chk("rst_tx_data", {16'd0, tx_data}, 32'd0);
    chk("rst_arb_state", {30'd0, arb_state}, 32'd0);
    chk("rst_vm_ready", {31'd0, vm_ready}, 32'd1);
    chk("rst_aud_busy", {31'd0, aud_busy}, 32'd0);
    chk("rst_drop", {24'd0, aud_drop_count}, 32'd0);
    chk("rst_ovf", {31'd0, ctl_overflow}, 32'd0);

    // Single control packet: pulse at cycle 10, issued at 12, busy 13..20
    busy_len = 8;
    while (cyc < 10) tick();
    expect_tx(C_CTL, 16'h2A01, 12, 12);
    send_ctl(16'h2A01);
    while (cyc < 15) tick();
    expect_tx(C_CTL, 16'h0B0B, 21, 23);
    send_ctl(16'h0B0B);
    chk("hold_tx_data", {16'd0, tx_data}, 32'h2A01);
    chk("hold_tx_cmd", {30'd0, tx_cmd}, {30'd0, C_CTL});
    wait_idle("single", 40);
    chk("idle_tx_cmd", {30'd0, tx_cmd}, 32'd0);

    // Priority then round-robin (rr_last = audio, so voicemail goes first)
    busy_len = 3;
    force_busy = 1'b1;
    send_ctl(16'hC0C0);
    send_aud(16'h1111);
    send_vm(16'h2222);
    expect_tx(C_CTL, 16'hC0C0, 0, 1 << 30);
    expect_tx(C_VM,  16'h2222, 0, 1 << 30);
    expect_tx(C_AUD, 16'h1111, 0, 1 << 30);
    force_busy = 1'b0;
    wait_idle("rr1", 60);
    force_busy = 1'b1;
    send_aud(16'h3333);
    send_vm(16'h4444);
    expect_tx(C_VM,  16'h4444, 0, 1 << 30);
    expect_tx(C_AUD, 16'h3333, 0, 1 << 30);
    force_busy = 1'b0;
    wait_idle("rr2", 60);

    // Audio overwrite while transport busy
    force_busy = 1'b1;
    send_aud(16'hA000);
    chk("aud_busy_first", {31'd0, aud_busy}, 32'd1);
    send_aud(16'hA001);
    send_aud(16'hA002);
    send_aud(16'hA003);
    send_aud(16'hA004);
    chk("aud_drop_4", {24'd0, aud_drop_count}, 32'd4);
    expect_tx(C_AUD, 16'hA004, 0, 1 << 30);
    force_busy = 1'b0;
    wait_idle("overwrite", 40);
    chk("aud_busy_empty", {31'd0, aud_busy}, 32'd0);

    // Audio push coincident with its pop is not a drop
    busy_len = 2;
    c = cyc;
    expect_tx(C_AUD, 16'hB000, c + 2, c + 2);
    expect_tx(C_AUD, 16'hB001, 0, 1 << 30);
    send_aud(16'hB000);
    send_aud(16'hB001);
    chk("drop_push_pop", {24'd0, aud_drop_count}, 32'd4);
    wait_idle("pushpop", 40);

    // Control overflow: third word lost, first two in order
    busy_len = 3;
    force_busy = 1'b1;
    send_ctl(16'hD001);
    send_ctl(16'hD002);
    chk("ovf_at_full", {31'd0, ctl_overflow}, 32'd0);
    send_ctl(16'hD003);
    chk("ovf_sticky", {31'd0, ctl_overflow}, 32'd1);
    expect_tx(C_CTL, 16'hD001, 0, 1 << 30);
    expect_tx(C_CTL, 16'hD002, 0, 1 << 30);
    force_busy = 1'b0;
    wait_idle("overflow", 60);

    // Busy timeout: busy never rises, WAIT_BUSY lasts TO cycles
    busy_len = 0;
    c = cyc;
    expect_tx(C_CTL, 16'hE001, c + 2, c + 2);
    expect_tx(C_CTL, 16'hE002, c + 3 + TO, c + 3 + TO);
    send_ctl(16'hE001);
    send_ctl(16'hE002);
    while (cyc < c + 1 + TO) tick();
    chk("timeout_wait", {30'd0, arb_state}, 32'd1);
    tick();
    chk("timeout_idle", {30'd0, arb_state}, 32'd0);
    wait_idle("timeout", 40);
    busy_len = 3;

    // Flush discards pending audio/voicemail, including a coincident word
    force_busy = 1'b1;
    send_aud(16'h5555);
    send_vm(16'h6666);
    chk("vm_ready_full", {31'd0, vm_ready}, 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_vm_ready", {31'd0, vm_ready}, 32'd1);
    chk("flush_aud_busy", {31'd0, aud_busy}, 32'd0);
    flush = 1'b1; aud_valid = 1'b1; aud_data = 16'h5A5A; vm_valid = 1'b1; vm_data = 16'h6A6A;
    tick();
    flush = 1'b0; aud_valid = 1'b0; vm_valid = 1'b0;
    chk("flush_coinc_aud", {31'd0, aud_busy}, 32'd0);
    chk("flush_coinc_vm", {31'd0, vm_ready}, 32'd1);
    chk("flush_no_drop", {24'd0, aud_drop_count}, 32'd4);
    force_busy = 1'b0;
    repeat (10) tick();

    // Reset while in WAIT_DONE
    busy_len = 20;
    expect_tx(C_CTL, 16'h7777, 0, 1 << 30);
    send_ctl(16'h7777);
    c = 0;
    while (arb_state != 2'd2 && c < 10) begin tick(); c++; end
    chk("reach_wait_done", {30'd0, arb_state}, 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mid_rst_tx_cmd", {30'd0, tx_cmd}, 32'd0);
    chk("mid_rst_state", {30'd0, arb_state}, 32'd0);
    chk("mid_rst_drop", {24'd0, aud_drop_count}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ctl_overflow}, 32'd0);
    repeat (4) tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
